pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake and DEPTH-entry elastic buffer.

---
 rtl/pipe_stage_buf_pkg.sv | 20 ++
 rtl/pipe_stage_buf_mem.sv | 27 ++
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 tb/tb_pipe_stage_buf.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and helpers for the pipeline-stage elastic buffer.
package pipe_stage_buf_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned PIPE_OCC_MAX_W = 8;

    typedef logic [WORD_W-1:0]         word_t;
    typedef logic [15:0]               stat_cnt_t;
    typedef logic [PIPE_OCC_MAX_W-1:0] pipe_occ_t;

    // Bubble control bit pattern; replicated to the control-bundle width.
    localparam logic      PIPE_NOP_CTRL = 1'b0;
    localparam stat_cnt_t STAT_CNT_MAX  = 16'hFFFF;

    // Pointer width; a single-entry buffer still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_mem.sv
// Entry storage: DEPTH x W register array, one write port, one async read port.
// Entries are deliberately not reset; the owner gates outputs with valid.
module pipe_stage_buf_mem #(
    parameter int unsigned W     = 48,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the accepted word into its slot
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and a DEPTH-entry elastic buffer.
// Optional statistics counters enabled by defining PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned DATA_W = $bits(word_t),
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    output stat_cnt_t                  stall_cnt,
    output stat_cnt_t                  flush_cnt
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = CTRL_W + DATA_W;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count_nxt;
    logic [ENT_W-1:0] rd_ent;
    logic             push_c;
    logic             pop_c;

    assign push_c = in_valid & in_ready;
    assign pop_c  = out_valid & out_ready;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next occupancy from this edge's transfers
    always_comb begin
        count_nxt = occupancy;
        if (push_c && !pop_c) begin
            count_nxt = occupancy + OCC_W'(1);
        end else if (!push_c && pop_c) begin
            count_nxt = occupancy - OCC_W'(1);
        end
    end

    // Pointers, count and registered handshake flags; flush squashes everything
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occupancy <= count_nxt;
            out_valid <= (count_nxt != '0);
            in_ready  <= (count_nxt != OCC_W'(DEPTH));
        end
    end

    pipe_stage_buf_mem #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (push_c & ~flush),
        .waddr (wr_ptr),
        .wdata ({in_ctrl, in_data}),
        .raddr (rd_ptr),
        .rdata (rd_ent)
    );

    // Bubble gating: outputs are all-zero whenever no head entry is valid
    assign out_ctrl = out_valid ? rd_ent[ENT_W-1:DATA_W] : {CTRL_W{PIPE_NOP_CTRL}};
    assign out_data = out_valid ? rd_ent[DATA_W-1:0]     : '0;

`ifdef PIPE_STAGE_BUF_STATS_EN
    // Saturating stall / non-empty-flush counters, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != STAT_CNT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (occupancy != '0) && (flush_cnt != STAT_CNT_MAX)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance checked every cycle
// against queue-based models, plus directed handshake/flush/reset scenarios.
// Define PIPE_STAGE_BUF_STATS_EN to also cover the statistics counters.
module tb_pipe_stage_buf;

    logic CLK;
    logic RST;

    // Instance A: DEPTH=2, CTRL_W=16, DATA_W=32
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    // Instance B: DEPTH=3, CTRL_W=8, DATA_W=12
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [11:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
    logic [15:0] exp_stall, exp_flush;
`endif

    int checks = 0;
    int errors = 0;

    logic [47:0] qa[$];
    logic [19:0] qb[$];

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .DEPTH(2)) dut_a (
        .CLK(CLK), .RST(RST), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
    );

    pipe_stage_buf #(.DATA_W(12), .CTRL_W(8), .DEPTH(3)) dut_b (
        .CLK(CLK), .RST(RST), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ)
`ifdef PIPE_STAGE_BUF_STATS_EN
        , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances with their models
    task automatic check_all(input string tag);
        logic [47:0] ha;
        logic [19:0] hb;
        ha = (qa.size() != 0) ? qa[0] : 48'h0;
        hb = (qb.size() != 0) ? qb[0] : 20'h0;
        check({tag, "_a_valid"}, 64'(a_out_valid), 64'(qa.size() != 0));
        check({tag, "_a_ready"}, 64'(a_in_ready),  64'(qa.size() != 2));
        check({tag, "_a_occ"},   64'(a_occ),       64'(qa.size()));
        check({tag, "_a_ctrl"},  64'(a_out_ctrl),  64'(ha[47:32]));
        check({tag, "_a_data"},  64'(a_out_data),  64'(ha[31:0]));
        check({tag, "_b_valid"}, 64'(b_out_valid), 64'(qb.size() != 0));
        check({tag, "_b_ready"}, 64'(b_in_ready),  64'(qb.size() != 3));
        check({tag, "_b_occ"},   64'(b_occ),       64'(qb.size()));
        check({tag, "_b_ctrl"},  64'(b_out_ctrl),  64'(hb[19:12]));
        check({tag, "_b_data"},  64'(b_out_data),  64'(hb[11:0]));
`ifdef PIPE_STAGE_BUF_STATS_EN
        check({tag, "_a_stall"}, 64'(a_stall_cnt), 64'(exp_stall));
        check({tag, "_a_flush"}, 64'(a_flush_cnt), 64'(exp_flush));
`endif
    endtask

    // One clock: predict transfers from current inputs, advance models, check
    task automatic cycle(input string tag);
        bit          pa, pop_a, pb, pop_b;
        logic [47:0] wa;
        logic [19:0] wb;
        pa    = a_in_valid && (qa.size() != 2);
        pop_a = (qa.size() != 0) && a_out_ready;
        pb    = b_in_valid && (qb.size() != 3);
        pop_b = (qb.size() != 0) && b_out_ready;
        wa    = {a_in_ctrl, a_in_data};
        wb    = {b_in_ctrl, b_in_data};
`ifdef PIPE_STAGE_BUF_STATS_EN
        if (qa.size() != 0 && !a_out_ready && exp_stall != 16'hFFFF) exp_stall++;
        if (a_flush && qa.size() != 0 && exp_flush != 16'hFFFF) exp_flush++;
`endif
        @(posedge CLK);
        #1;
        if (a_flush) qa.delete();
        else begin
            if (pop_a) void'(qa.pop_front());
            if (pa) qa.push_back(wa);
        end
        if (b_flush) qb.delete();
        else begin
            if (pop_b) void'(qb.pop_front());
            if (pb) qb.push_back(wb);
        end
        check_all(tag);
    endtask

    task automatic push_a(input logic [15:0] c, input logic [31:0] d);
        a_in_valid = 1'b1;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    initial begin
        RST = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = '0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = '0; b_in_data = '0;
`ifdef PIPE_STAGE_BUF_STATS_EN
        exp_stall = '0;
        exp_flush = '0;
`endif
        #12;
        check_all("reset");
        RST = 1'b0;

        // Back-to-back streaming with 1-cycle latency
        a_out_ready = 1'b1;
        push_a(16'h0001, 32'hA); cycle("t2_1");
        check("t2_head_a", 64'(a_out_data), 64'hA);
        push_a(16'h0002, 32'hB); cycle("t2_2");
        check("t2_head_b", 64'(a_out_data), 64'hB);
        push_a(16'h0003, 32'hC); cycle("t2_3");
        check("t2_head_c", 64'(a_out_data), 64'hC);
        check("t2_ready",  64'(a_in_ready), 64'h1);
        a_in_valid = 1'b0; cycle("t2_4");

        // Back-pressure: two accepted, third held until in_ready returns
        a_out_ready = 1'b0;
        push_a(16'h0011, 32'hA); cycle("t3_1");
        push_a(16'h0012, 32'hB); cycle("t3_2");
        check("t3_full_ready", 64'(a_in_ready), 64'h0);
        check("t3_full_occ",   64'(a_occ),      64'h2);
        push_a(16'h0013, 32'hC);
        cycle("t3_3"); cycle("t3_4");
        check("t3_stall_head", 64'(a_out_data), 64'hA);
        check("t3_stall_ctrl", 64'(a_out_ctrl), 64'h0011);
        a_out_ready = 1'b1;
        cycle("t3_5");
        check("t3_drain_b", 64'(a_out_data), 64'hB);
        cycle("t3_6");
        check("t3_accept_c", 64'(a_out_data), 64'hC);
        a_in_valid = 1'b0;
        cycle("t3_7");

        // Flush at full with simultaneous push and pop
        a_out_ready = 1'b0;
        push_a(16'h0021, 32'h1); cycle("t4_1");
        push_a(16'h0022, 32'h2); cycle("t4_2");
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        push_a(16'h00DD, 32'hDEAD);
        cycle("t4_3");
        check("t4_occ",  64'(a_occ),      64'h0);
        check("t4_ctrl", 64'(a_out_ctrl), 64'h0);
        a_flush = 1'b0; a_in_valid = 1'b0;
        cycle("t4_4");
        check("t4_no_ghost", 64'(a_out_valid), 64'h0);

        // Asynchronous reset mid-stream with occupancy 2
        a_out_ready = 1'b0;
        push_a(16'h0031, 32'h5); cycle("t1_1");
        push_a(16'h0032, 32'h6); cycle("t1_2");
        a_in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        qa.delete();
        qb.delete();
`ifdef PIPE_STAGE_BUF_STATS_EN
        exp_stall = '0;
        exp_flush = '0;
`endif
        check("t1_valid", 64'(a_out_valid), 64'h0);
        check("t1_ctrl",  64'(a_out_ctrl),  64'h0);
        check("t1_ready", 64'(a_in_ready),  64'h1);
        check("t1_occ",   64'(a_occ),       64'h0);
        RST = 1'b0;

        // Randomized traffic on both instances, wraps pointers many times
        for (int i = 0; i < 300; i++) begin
            a_in_valid  = 1'($urandom_range(0, 3) != 0);
            a_out_ready = 1'($urandom_range(0, 2) != 0);
            a_flush     = 1'($urandom_range(0, 19) == 0);
            a_in_ctrl   = 16'($urandom);
            a_in_data   = 32'($urandom);
            b_in_valid  = 1'($urandom_range(0, 3) != 0);
            b_out_ready = 1'($urandom_range(0, 2) != 0);
            b_flush     = 1'($urandom_range(0, 29) == 0);
            b_in_ctrl   = 8'($urandom);
            b_in_data   = 12'($urandom);
            cycle("t5_rand");
        end
        a_flush = 0; a_in_valid = 0; b_flush = 0; b_in_valid = 0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) cycle("t5_drain");

`ifdef PIPE_STAGE_BUF_STATS_EN
        // Statistics: 5 stalls, one non-empty and one empty flush, then saturation
        #2; RST = 1'b1; #1;
        qa.delete(); qb.delete();
        exp_stall = '0; exp_flush = '0;
        RST = 1'b0;
        a_out_ready = 1'b0;
        push_a(16'h0041, 32'h7); cycle("t6_push");
        a_in_valid = 1'b0;
        repeat (5) cycle("t6_stall");
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        cycle("t6_flush1");
        cycle("t6_flush2");
        a_flush = 1'b0;
        check("t6_stall_cnt", 64'(a_stall_cnt), 64'd5);
        check("t6_flush_cnt", 64'(a_flush_cnt), 64'd1);
        a_out_ready = 1'b0;
        push_a(16'h0042, 32'h8); cycle("t6_push2");
        a_in_valid = 1'b0;
        repeat (70000) @(posedge CLK);
        #1;
        check("t6_saturate", 64'(a_stall_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
